// File: rtl/roberts_stream.sv
// Streaming Roberts-cross edge detector. It takes one raster-order pixel per
// handshake, keeps one line of history internally and produces one saturated
// gradient-magnitude pixel per input pixel through a three-stage pipeline.
module roberts_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             cfg_mode,
    input  logic             cfg_bin,
    input  logic [PIX_W-1:0] cfg_thresh,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    // Position of the next pixel to be accepted
    logic [COL_W-1:0] r_colCnt;
    logic [ROW_W-1:0] r_rowCnt;

    // Frame configuration, captured at pixel (0,0)
    logic             r_cfgMode;
    logic             r_cfgBin;
    logic [PIX_W-1:0] r_cfgThresh;

    // Previous row of pixels, plus the two pixels to the left of the current one
    logic [PIX_W-1:0] r_lineBuf [IMG_W];
    logic [PIX_W-1:0] r_prevPix;
    logic [PIX_W-1:0] r_prevTop;

    // Stage 1: the 2x2 window and its side-band information
    logic             r_s1Valid;
    logic [PIX_W-1:0] r_s1Cur;
    logic [PIX_W-1:0] r_s1Left;
    logic [PIX_W-1:0] r_s1Top;
    logic [PIX_W-1:0] r_s1TopLeft;
    logic             r_s1Border;
    logic             r_s1Last;
    logic             r_s1Mode;
    logic             r_s1Bin;
    logic [PIX_W-1:0] r_s1Thresh;

    // Stage 2: absolute gradients
    logic             r_s2Valid;
    logic [PIX_W-1:0] r_s2AbsX;
    logic [PIX_W-1:0] r_s2AbsY;
    logic             r_s2Border;
    logic             r_s2Last;
    logic             r_s2Mode;
    logic             r_s2Bin;
    logic [PIX_W-1:0] r_s2Thresh;

    logic             w_advance;
    logic             w_accept;
    logic             w_frameStart;
    logic [PIX_W-1:0] w_top;
    logic             w_cfgMode;
    logic             w_cfgBin;
    logic [PIX_W-1:0] w_cfgThresh;
    logic signed [PIX_W:0] w_gx;
    logic signed [PIX_W:0] w_gy;
    logic [PIX_W-1:0] w_absX;
    logic [PIX_W-1:0] w_absY;
    logic [PIX_W:0]   w_sum;
    logic [PIX_W-1:0] w_mag;
    logic [PIX_W-1:0] w_result;

    // The whole pipeline moves together whenever the output register is free
    assign w_advance    = !out_valid || out_ready;
    assign in_ready     = w_advance;
    assign w_accept     = in_valid && w_advance;
    assign w_frameStart = (r_colCnt == '0) && (r_rowCnt == '0);
    assign w_top        = r_lineBuf[r_colCnt];

    // Pixel (0,0) uses the live configuration, the rest of the frame the captured one
    assign w_cfgMode   = w_frameStart ? cfg_mode   : r_cfgMode;
    assign w_cfgBin    = w_frameStart ? cfg_bin    : r_cfgBin;
    assign w_cfgThresh = w_frameStart ? cfg_thresh : r_cfgThresh;

    // Raster position counters, wrapping at line and frame ends
    always_ff @(posedge clk) begin
        if (rst) begin
            r_colCnt <= '0;
            r_rowCnt <= '0;
        end else if (w_accept) begin
            if (r_colCnt == COL_MAX) begin
                r_colCnt <= '0;
                r_rowCnt <= (r_rowCnt == ROW_MAX) ? '0 : r_rowCnt + 1'b1;
            end else begin
                r_colCnt <= r_colCnt + 1'b1;
            end
        end
    end

    // Hold the configuration of the frame that is currently entering
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfgMode   <= 1'b0;
            r_cfgBin    <= 1'b0;
            r_cfgThresh <= '0;
        end else if (w_accept && w_frameStart) begin
            r_cfgMode   <= cfg_mode;
            r_cfgBin    <= cfg_bin;
            r_cfgThresh <= cfg_thresh;
        end
    end

    // Line buffer: the old value at this column is read before it is replaced
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lineBuf[r_colCnt] <= in_pix;
        end
    end

    // Stage 1: assemble the window around the accepted pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid   <= 1'b0;
            r_s1Cur     <= '0;
            r_s1Left    <= '0;
            r_s1Top     <= '0;
            r_s1TopLeft <= '0;
            r_s1Border  <= 1'b0;
            r_s1Last    <= 1'b0;
            r_s1Mode    <= 1'b0;
            r_s1Bin     <= 1'b0;
            r_s1Thresh  <= '0;
            r_prevPix   <= '0;
            r_prevTop   <= '0;
        end else if (w_advance) begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1Cur     <= in_pix;
                r_s1Left    <= r_prevPix;
                r_s1Top     <= w_top;
                r_s1TopLeft <= r_prevTop;
                r_s1Border  <= (r_rowCnt == '0) || (r_colCnt == '0);
                r_s1Last    <= (r_rowCnt == ROW_MAX) && (r_colCnt == COL_MAX);
                r_s1Mode    <= w_cfgMode;
                r_s1Bin     <= w_cfgBin;
                r_s1Thresh  <= w_cfgThresh;
                r_prevPix   <= in_pix;
                r_prevTop   <= w_top;
            end
        end
    end

    // Signed diagonal differences and their magnitudes
    always_comb begin
        w_gx   = $signed({1'b0, r_s1Cur})  - $signed({1'b0, r_s1TopLeft});
        w_gy   = $signed({1'b0, r_s1Left}) - $signed({1'b0, r_s1Top});
        w_absX = w_gx[PIX_W] ? PIX_W'(-w_gx) : w_gx[PIX_W-1:0];
        w_absY = w_gy[PIX_W] ? PIX_W'(-w_gy) : w_gy[PIX_W-1:0];
    end

    // Stage 2: register the absolute gradients
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid  <= 1'b0;
            r_s2AbsX   <= '0;
            r_s2AbsY   <= '0;
            r_s2Border <= 1'b0;
            r_s2Last   <= 1'b0;
            r_s2Mode   <= 1'b0;
            r_s2Bin    <= 1'b0;
            r_s2Thresh <= '0;
        end else if (w_advance) begin
            r_s2Valid  <= r_s1Valid;
            r_s2AbsX   <= w_absX;
            r_s2AbsY   <= w_absY;
            r_s2Border <= r_s1Border;
            r_s2Last   <= r_s1Last;
            r_s2Mode   <= r_s1Mode;
            r_s2Bin    <= r_s1Bin;
            r_s2Thresh <= r_s1Thresh;
        end
    end

    // Combine magnitudes, saturate, force borders to zero, then binarise
    always_comb begin
        w_sum = {1'b0, r_s2AbsX} + {1'b0, r_s2AbsY};
        if (r_s2Mode) begin
            w_mag = (r_s2AbsX > r_s2AbsY) ? r_s2AbsX : r_s2AbsY;
        end else begin
            w_mag = w_sum[PIX_W] ? '1 : w_sum[PIX_W-1:0];
        end
        if (r_s2Border) begin
            w_mag = '0;
        end
        w_result = w_mag;
        if (r_s2Bin) begin
            w_result = (w_mag >= r_s2Thresh) ? '1 : '0;
        end
    end

    // Stage 3: output register, frozen while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_last  <= 1'b0;
        end else if (w_advance) begin
            out_valid <= r_s2Valid;
            out_pix   <= w_result;
            out_last  <= r_s2Valid && r_s2Last;
        end
    end

endmodule

// File: tb/tb_roberts_stream.sv
// Self-checking bench for roberts_stream on a small 4x3 image: directed frames,
// backpressure, frame wrap with configuration capture, mid-frame reset and
// random frames, all compared against a plain-arithmetic reference model.
module tb_roberts_stream;

    localparam int PIX_W = 8;
    localparam int IMG_W = 4;
    localparam int IMG_H = 3;
    localparam int NPIX  = IMG_W * IMG_H;

    logic             clk = 1'b0;
    logic             rst;
    logic [PIX_W-1:0] in_pix;
    logic             in_valid;
    logic             in_ready;
    logic             cfg_mode;
    logic             cfg_bin;
    logic [PIX_W-1:0] cfg_thresh;
    logic [PIX_W-1:0] out_pix;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_last;

    int checkCount = 0;
    int passCount  = 0;
    int cycleCnt   = 0;
    int readyMode  = 0;
    int patIdx     = 0;
    bit monOn      = 1'b0;
    bit prevStall  = 1'b0;
    int prevPix;
    int prevLast;
    int firstAccept = -1;
    int firstOut    = -1;
    int outIdx      = 0;
    int expHead;
    int frame [NPIX];
    int expPix [$];
    int expLast [$];

    roberts_stream #(
        .PIX_W(PIX_W),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pix    (in_pix),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cfg_mode  (cfg_mode),
        .cfg_bin   (cfg_bin),
        .cfg_thresh(cfg_thresh),
        .out_pix   (out_pix),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Single comparison point for every check
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Downstream readiness: always ready, 1,0,0,1 pattern, or random
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0: out_ready = 1'b1;
            1: begin
                out_ready = ((patIdx % 4) == 0) || ((patIdx % 4) == 3);
                patIdx++;
            end
            default: out_ready = ($urandom_range(0, 99) < 65);
        endcase
    end

    // Output monitor: scoreboard, stall stability and ready rule
    always @(negedge clk) begin
        if (rst || !monOn) begin
            prevStall = 1'b0;
        end else begin
            checkOutput("inReady", int'(in_ready), int'(!out_valid || out_ready));
            if (prevStall) begin
                checkOutput("stallValid", int'(out_valid), 1);
                checkOutput("stallPix", int'(out_pix), prevPix);
                checkOutput("stallLast", int'(out_last), prevLast);
            end
            if (out_valid && firstOut < 0) firstOut = cycleCnt;
            if (out_valid && out_ready) begin
                if (expPix.size() == 0) begin
                    checkOutput("unexpectedOutput", expPix.size(), 1);
                end else begin
                    expHead = expPix.pop_front();
                    checkOutput($sformatf("pix[%0d]", outIdx), int'(out_pix), expHead);
                    expHead = expLast.pop_front();
                    checkOutput($sformatf("last[%0d]", outIdx), int'(out_last), expHead);
                    outIdx++;
                end
            end
            prevStall = out_valid && !out_ready;
            prevPix   = int'(out_pix);
            prevLast  = int'(out_last);
        end
    end

    // Reference model: Roberts cross straight from the pixel grid
    task automatic buildExpected(input int mode, input int bin, input int thresh);
        int gx, gy, ax, ay, mag;
        for (int r = 0; r < IMG_H; r++) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (r == 0 || c == 0) begin
                    mag = 0;
                end else begin
                    gx  = frame[r*IMG_W + c]     - frame[(r-1)*IMG_W + c - 1];
                    gy  = frame[r*IMG_W + c - 1] - frame[(r-1)*IMG_W + c];
                    ax  = (gx < 0) ? -gx : gx;
                    ay  = (gy < 0) ? -gy : gy;
                    if (mode != 0) mag = (ax > ay) ? ax : ay;
                    else           mag = (ax + ay > 255) ? 255 : ax + ay;
                end
                if (bin != 0) mag = (mag >= thresh) ? 255 : 0;
                expPix.push_back(mag);
                expLast.push_back((r == IMG_H-1 && c == IMG_W-1) ? 1 : 0);
            end
        end
    endtask

    task automatic fillUniform(input int v);
        for (int i = 0; i < NPIX; i++) frame[i] = v;
    endtask

    task automatic fillStep();
        for (int i = 0; i < NPIX; i++) frame[i] = ((i % IMG_W) >= 2) ? 200 : 0;
    endtask

    task automatic fillRandom();
        for (int i = 0; i < NPIX; i++) frame[i] = $urandom_range(0, 255);
    endtask

    // Offer one pixel, optionally after an idle cycle, until it is accepted
    task automatic drivePixel(input int pix, input int gapPct);
        bit done;
        done = 1'b0;
        if ($urandom_range(0, 99) < gapPct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_pix   = PIX_W'(pix);
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
                if (firstAccept < 0) firstAccept = cycleCnt;
            end
            @(posedge clk); #1;
        end
        checkOutput("accept", int'(done), 1);
    endtask

    // Send one whole frame, queueing its expected output first
    task automatic applyStimulus(input int mode, input int bin, input int thresh,
                                 input int midChange, input int gapPct);
        buildExpected(mode, bin, thresh);
        for (int i = 0; i < NPIX; i++) begin
            if (i == 0) begin
                cfg_mode   = mode[0];
                cfg_bin    = bin[0];
                cfg_thresh = PIX_W'(thresh);
            end
            drivePixel(frame[i], gapPct);
            if (i == 0 && midChange != 0) begin
                cfg_mode   = ~cfg_mode;
                cfg_bin    = $urandom_range(0, 1);
                cfg_thresh = PIX_W'($urandom_range(0, 255));
            end
        end
        in_valid = 1'b0;
    endtask

    // Wait, with a bound, until every queued output has been seen
    task automatic drain();
        for (int t = 0; t < 500 && expPix.size() != 0; t++) @(posedge clk);
        #1;
        checkOutput("drain", expPix.size(), 0);
    endtask

    // Main sequence
    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_pix     = '0;
        cfg_mode   = 1'b0;
        cfg_bin    = 1'b0;
        cfg_thresh = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetValid", int'(out_valid), 0);
        checkOutput("resetPix", int'(out_pix), 0);
        checkOutput("resetLast", int'(out_last), 0);
        checkOutput("resetReady", int'(in_ready), 1);
        rst   = 1'b0;
        monOn = 1'b1;

        readyMode = 0;
        fillUniform(100);
        applyStimulus(0, 0, 0, 0, 0);
        drain();
        checkOutput("latency", firstOut - firstAccept, 3);

        fillStep();
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 1, 150, 0, 0);
        applyStimulus(1, 1, 201, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        drain();

        readyMode = 1;
        patIdx    = 0;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        drain();

        readyMode = 0;
        @(posedge clk); #1;
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        drain();

        monOn = 1'b0;
        fillRandom();
        for (int i = 0; i < 6; i++) drivePixel(frame[i], 0);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("midResetValid", int'(out_valid), 0);
        checkOutput("midResetLast", int'(out_last), 0);
        checkOutput("midResetReady", int'(in_ready), 1);
        expPix.delete();
        expLast.delete();
        monOn = 1'b1;
        fillStep();
        applyStimulus(0, 0, 0, 0, 0);
        drain();

        readyMode = 2;
        for (int f = 0; f < 8; f++) begin
            fillRandom();
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 1),
                          $urandom_range(0, 255), 1, 20);
        end
        drain();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/roberts_stream.md
Name: roberts_stream

Overview:
- Streaming, parametrised Roberts-cross edge detector; next generation of the team's 3x3-window Roberts block.
- Accepts one raster-order pixel per handshake and keeps its own one-line buffer, so upstream no longer supplies a window.
- Produces one saturated gradient-magnitude pixel per input pixel, with valid/ready backpressure, frame-end marking, selectable magnitude mode and optional binarisation.
- Sits between the pixel source (camera/DMA unpack) and the frame writer.

Parameters:
- PIX_W, 8, pixel width in bits (unsigned).
- IMG_W, 640, pixels per line; must be >= 2.
- IMG_H, 480, lines per frame; must be >= 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_pix  in  PIX_W  input pixel, raster order.
- in_valid  in  1  in_pix valid.
- in_ready  out  1  block accepts in_pix this cycle.
- cfg_mode  in  1  0 = |gx|+|gy|; 1 = max(|gx|,|gy|).
- cfg_bin  in  1  1 = binarise output.
- cfg_thresh  in  PIX_W  binarisation threshold.
- out_pix  out  PIX_W  edge magnitude.
- out_valid  out  1  out_pix valid.
- out_ready  in  1  downstream accepts out_pix.
- out_last  out  1  high with the final pixel of each frame.

Behaviour:
- Reset: out_pix = 0, out_valid = 0, out_last = 0, in_ready = 1. Row/column counters and pipeline valids clear; line-buffer contents are don't-care. Reset mid-frame discards all in-flight pixels; the next accepted pixel is pixel (0,0).
- Handshake: a transfer occurs when valid && ready on the same edge.
  - Global advance = !out_valid || out_ready; in_ready = advance.
  - When stalled, out_pix, out_valid and out_last hold stable and all stages freeze.
- Pipeline: 3 stages; latency exactly 3 cycles from input accept to out_valid when never stalled; throughput 1 pixel/cycle.
  - S1: window form (line-buffer read/write, left and top-left registers).
  - S2: gx, gy and absolute values.
  - S3: mode combine, saturation, threshold.
- Window for the current pixel P(r,c):
  - gx = P(r,c) - P(r-1,c-1).
  - gy = P(r,c-1) - P(r-1,c).
  - Line buffer: IMG_W entries holding row r-1; written with P(r,c) at column c after its old value is read.
- Arithmetic:
  - gx, gy signed, PIX_W+1 bits; absolute values unsigned, PIX_W bits.
  - Mode 0: PIX_W+1-bit sum; any value > 2^PIX_W-1 saturates to 2^PIX_W-1.
  - Mode 1: larger of the two, no saturation needed.
  - cfg_bin = 1: out_pix = (mag >= cfg_thresh) ? all-ones : 0.
- Borders: pixels with r = 0 or c = 0 output 0, before binarisation. With cfg_bin = 1 and cfg_thresh = 0 they output all-ones.
- Counters:
  - Column wraps at IMG_W-1, which increments row.
  - Row wraps at IMG_H-1 back to frame start.
  - out_last asserts with the output of pixel (IMG_H-1, IMG_W-1).
  - Back-to-back frames need no gap; row 0 of a new frame never uses previous-frame data.
- Config: cfg_mode, cfg_bin and cfg_thresh are captured when pixel (0,0) is accepted and held for the whole frame. Mid-frame changes take effect next frame.
- Simultaneous events: an input accept and an output accept in the same cycle are both honoured with no bubble. rst wins over every transfer.

Test Plan:
(PIX_W = 8, IMG_W = 4, IMG_H = 3 unless noted.)
- Uniform frame, all pixels 100, out_ready = 1: 12 outputs, all 0. out_last only on the 12th. First out_valid exactly 3 cycles after the first accept.
- Vertical step, columns 0-1 = 0 and columns 2-3 = 200, mode 0:
  - Row 0 outputs 0,0,0,0.
  - Rows 1 and 2 output 0,0,255,0 (gx = 200, gy = -200, sum 400 saturates).
  - Same frame in mode 1: column 2 of rows 1-2 = 200.
- Binarisation: step frame with mode 1, cfg_bin = 1, cfg_thresh = 150 → 255 at column 2 of rows 1-2, all others 0. With cfg_thresh = 201 → all 0.
- Backpressure: out_ready driven 1,0,0,1 repeating, in_valid always 1.
  - Output stream is identical in value and order to the unstalled run.
  - out_pix stays stable while out_valid && !out_ready.
  - in_ready = 0 exactly on stalled cycles.
- Frame wrap and config capture: two step frames back-to-back; cfg_mode toggled 0→1 during frame 1.
  - Frame 1 uses mode 0 throughout.
  - Frame 2 row 0 is all 0, and frame 2 uses mode 1.
  - out_last fires once per frame.
- Mid-frame reset: assert rst for 1 cycle after 6 accepts.
  - out_valid = 0 on the following cycle.
  - A fresh step frame then produces exactly the reference step output.
